// File: rtl/pc_sequencer_pkg.sv
// Shared IF-stage definitions: sequencer state encoding, next-PC select codes
// and the default reset vector / sequential step.
package pc_sequencer_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_SEQ    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_CALL   = 3'd4,
        SEL_RET    = 3'd5,
        SEL_STACK  = 3'd6
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-flow event and return-stack signals between the IF-stage sequencer
// and its environment; the sequencer is the slave side.
interface pc_sequencer_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] jmp_target;
    logic [31:0] stack_data;
    logic        stack_err;
    logic [31:0] pc;
    logic        stack_push;
    logic        stack_pop;
    logic [31:0] stack_pc;
    logic        fetch_valid;
    logic        fault;

    modport master (
        output stall, br_taken, br_target, jump, call, ret, jmp_target,
               stack_data, stack_err,
        input  pc, stack_push, stack_pop, stack_pc, fetch_valid, fault
    );

    modport slave (
        input  stall, br_taken, br_target, jump, call, ret, jmp_target,
               stack_data, stack_err,
        output pc, stack_push, stack_pop, stack_pc, fetch_valid, fault
    );
endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Next-PC priority mux: picks the winning control-flow event for the current
// state and produces the PC to load on the next edge.
module next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] PC_STEP = DEF_PC_STEP
) (
    input  state_e      state,
    input  logic        stall,
    input  logic        ret,
    input  logic        call,
    input  logic        br_taken,
    input  logic        jump,
    input  logic [31:0] pc,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic [31:0] stack_data,
    output pc_sel_e     sel,
    output logic [31:0] pc_next
);

    always_comb begin
        sel = SEL_HOLD;
        unique case (state)
            ST_RUN: begin
                if (!stall) begin
                    if (ret)           sel = SEL_RET;
                    else if (call)     sel = SEL_CALL;
                    else if (br_taken) sel = SEL_BRANCH;
                    else if (jump)     sel = SEL_JUMP;
                    else               sel = SEL_SEQ;
                end
            end
            // the pop is already in flight, so stall cannot hold this load
            ST_RET_WAIT: sel = SEL_STACK;
            default:     sel = SEL_HOLD;
        endcase
    end

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ:             pc_next = pc + PC_STEP;
            SEL_BRANCH:          pc_next = br_target;
            SEL_JUMP, SEL_CALL:  pc_next = jmp_target;
            SEL_STACK:           pc_next = stack_data;
            default:             pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC sequencer: sequential fetch, branch/jump/call/return handling
// against an external return stack, and a sticky stack-fault state.
//
// state       | meaning
// ST_RUN      | fetching; events accepted when not stalled
// ST_RET_WAIT | pop issued, pc loads stack_data on the next edge
// ST_FAULT    | stack over/underflow seen; frozen until reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    pc_sel_e     sel;

    next_pc_mux #(.PC_STEP(PC_STEP)) u_next_pc_mux (
        .state      (state_q),
        .stall      (bus.stall),
        .ret        (bus.ret),
        .call       (bus.call),
        .br_taken   (bus.br_taken),
        .jump       (bus.jump),
        .pc         (pc_q),
        .br_target  (bus.br_target),
        .jmp_target (bus.jmp_target),
        .stack_data (bus.stack_data),
        .sel        (sel),
        .pc_next    (pc_d)
    );

    always_comb begin
        state_d = state_q;
        case (sel)
            SEL_RET:   state_d = ST_RET_WAIT;
            SEL_STACK: state_d = ST_RUN;
            default:   state_d = state_q;
        endcase
        // a stack error is a hard fault and overrides stall
        if (state_q != ST_FAULT && bus.stack_err) state_d = ST_FAULT;
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_pc    = pc_q + PC_STEP;
    assign bus.stack_push  = (sel == SEL_CALL);
    assign bus.stack_pop   = (sel == SEL_RET);
    assign bus.fetch_valid = (state_q == ST_RUN);
    assign bus.fault       = fault_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, is the sequential PC increment in bytes.
REQ-003 clk  input  1  Rising-edge clock for all state.
REQ-004 reset  input  1  Reset: synchronous, active-high, sampled on rising clk.
REQ-005 stall  input  1  Holds PC, state and stack requests for the cycle.
REQ-006 br_taken  input  1  A conditional branch resolved taken this cycle.
REQ-007 br_target  input  32  Branch destination.
REQ-008 jump  input  1  Unconditional jump this cycle.
REQ-009 call  input  1  Call: jump plus push of the return address.
REQ-010 ret  input  1  Return: pop the return address and jump to it.
REQ-011 jmp_target  input  32  Destination for jump and call.
REQ-012 stack_data  input  32  Return-stack read data, valid the cycle after stack_pop.
REQ-013 stack_err  input  1  Return-stack overflow/underflow flag.
REQ-014 pc  output  32  Current fetch address, registered.
REQ-015 stack_push  output  1  One-cycle write strobe to the return stack.
REQ-016 stack_pop  output  1  One-cycle read strobe to the return stack.
REQ-017 stack_pc  output  32  Return address to push, equal to pc + PC_STEP.
REQ-018 fetch_valid  output  1  High when pc is a valid fetch address this cycle.
REQ-019 fault  output  1  Sticky stack-fault indicator.

Function
REQ-020 The sequencer SHALL implement three states: RUN, RET_WAIT and FAULT.
REQ-021 In RUN with no event and stall=0, pc SHALL advance by PC_STEP every cycle, wrapping modulo 2^32.
REQ-022 Event priority SHALL be ret > call > br_taken > jump > sequential, and lower-priority events in the same cycle SHALL be ignored.
REQ-023 On a call in RUN, stack_push SHALL be high that cycle, stack_pc SHALL equal pc + PC_STEP, and pc SHALL become jmp_target on the next edge.
REQ-024 On br_taken or jump in RUN, pc SHALL become the corresponding target on the next edge, with no stack strobe.
REQ-025 On a ret in RUN, stack_pop SHALL be high that cycle, pc SHALL hold, and the state SHALL become RET_WAIT.
REQ-026 In RET_WAIT, fetch_valid SHALL be 0, all event inputs SHALL be ignored, pc SHALL load stack_data on the next edge, and the state SHALL return to RUN, giving a return latency of 2 cycles.
REQ-027 stall=1 SHALL freeze pc and state and force stack_push=0 and stack_pop=0; an event present during stall SHALL be acted on only when presented with stall=0.
REQ-028 stall SHALL NOT delay the RET_WAIT-to-RUN transition, because the stack read has already been issued.
REQ-029 stack_err=1 sampled in RUN or RET_WAIT SHALL move the state to FAULT on the next edge.
REQ-030 In FAULT, fault SHALL be 1, fetch_valid SHALL be 0, pc SHALL hold, and no stack strobe SHALL be issued.
REQ-031 FAULT SHALL be left only by reset.
REQ-032 stack_push and stack_pop SHALL never be high in the same cycle.
REQ-033 fetch_valid SHALL be 1 in RUN and 0 in all other states.

Reset
REQ-034 Reset SHALL force pc=RESET_VECTOR, state=RUN, fault=0, stack_push=0, stack_pop=0 and fetch_valid=1.
REQ-035 Reset asserted in RET_WAIT SHALL abandon the pending pop, so stack_data is not loaded.
REQ-036 Reset SHALL have priority over every other input, including stall.

Structure
REQ-037 The state encoding and the PC_STEP and RESET_VECTOR defaults SHALL live in the shared IF-stage package.
REQ-038 The next-PC priority mux SHALL be one combinational sub-module, next_pc_mux; state and registers SHALL stay in pc_sequencer.

Verification
REQ-039 Reset, then 3 idle cycles -> pc = 0, 4, 8, 12, with fetch_valid=1 throughout.
REQ-040 call at pc=0x10 with jmp_target=0x100 -> stack_push=1 and stack_pc=0x14 that cycle, then pc=0x100.
REQ-041 ret at pc=0x104 with stack_data=0x14 in the next cycle -> stack_pop=1 for one cycle, pc=0x104 with fetch_valid=0 for one cycle, then pc=0x14.
REQ-042 call, ret and br_taken asserted together at pc=0x20 -> only stack_pop=1, and RET_WAIT is entered.
REQ-043 stall=1 for 2 cycles with call asserted -> pc unchanged and no push; call is taken on the first cycle with stall=0.
REQ-044 stack_err pulsed at pc=0x40 -> fault=1 and pc frozen at 0x44 until reset, after which pc=0 and fault=0.
